mtm_alu_rx_ctrl: RTL and testbench

Input-side controller for the mtm_Alu core. It deserialises the 1-bit `sin` stream into 11-bit frames and sequences the 8 DATA + 1 CMD packet protocol. It checks frame count, CRC4 and opcode, then presents one validated operation (A, B, OP) or one error code to the ALU core over a valid/ready handshake. It sits between the chip `sin` pin and the arithmetic core.

---
 rtl/mtm_alu_pkg.sv | 37 +++
 rtl/mtm_alu_rx_ctrl_if.sv | 22 ++
 rtl/mtm_alu_frame_rx.sv | 70 +++++++
 rtl/mtm_alu_rx_ctrl.sv | 143 ++++++++++++++
 tb/tb_mtm_alu_rx_ctrl.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mtm_alu_pkg.sv
// Shared types, constants and the CRC4 helper for the mtm_Alu input controller.
package mtm_alu_pkg;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b100,
        OP_SUB = 3'b101
    } op_e;

    typedef logic [2:0] err_t;

    localparam int ERR_DATA   = 2;
    localparam int ERR_CRC    = 1;
    localparam int ERR_OP     = 0;
    localparam int FRAME_BITS = 11;

    // x^4+x+1, init 0, message consumed MSB first.
    function automatic logic [3:0] crc4(input logic [67:0] data);
        logic [3:0] crc;
        logic       fb;
        crc = 4'h0;
        for (int i = 67; i >= 0; i--) begin
            fb  = crc[3] ^ data[i];
            crc = {crc[2:0], 1'b0} ^ {2'b00, fb, fb};
        end
        return crc;
    endfunction

    function automatic logic op_legal(input logic [2:0] op);
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB: return 1'b1;
            default:                       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mtm_alu_rx_ctrl_if.sv
// Result channel from the input controller to the ALU core (valid/ready plus overrun).
interface mtm_alu_rx_ctrl_if;
    import mtm_alu_pkg::*;

    logic        out_ready;
    logic        out_valid;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [2:0]  out_op;
    err_t        out_err;
    logic        overrun;

    modport master (
        input  out_ready,
        output out_valid, out_a, out_b, out_op, out_err, overrun
    );

    modport slave (
        output out_ready,
        input  out_valid, out_a, out_b, out_op, out_err, overrun
    );
endinterface

// File: rtl/mtm_alu_frame_rx.sv
// Serial frame receiver: start detect, 10-bit capture, one-cycle CHECK strobe, resync after a bad stop bit.
// rx_idle exists only when MTM_ALU_RX_TIMEOUT_EN is defined.
module mtm_alu_frame_rx
    import mtm_alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sin,
`ifdef MTM_ALU_RX_TIMEOUT_EN
    output logic       rx_idle,
`endif
    output logic       frame_done,
    output logic       frame_type,
    output logic [7:0] payload,
    output logic       frame_err
);
    typedef enum logic [1:0] {IDLE, RECV, CHECK, RESYNC} state_e;

    state_e                  state_reg, state_next;
    logic [FRAME_BITS-2:0]   shift_reg, shift_next;
    logic [3:0]              bit_cnt_reg, bit_cnt_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            shift_reg   <= shift_next;
            bit_cnt_reg <= bit_cnt_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        shift_next   = shift_reg;
        bit_cnt_next = bit_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (!sin) begin
                    state_next   = RECV;
                    bit_cnt_next = '0;
                end
            end
            RECV: begin
                shift_next = {shift_reg[FRAME_BITS-3:0], sin};
                if (bit_cnt_reg == 4'(FRAME_BITS - 2)) begin
                    state_next = CHECK;
                end else begin
                    bit_cnt_next = bit_cnt_reg + 4'd1;
                end
            end
            CHECK:   state_next = frame_err ? RESYNC : IDLE;
            RESYNC:  if (sin) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Captured layout: {type, payload[7:0], stop}.
    assign frame_done = (state_reg == CHECK);
    assign frame_type = shift_reg[FRAME_BITS-2];
    assign payload    = shift_reg[FRAME_BITS-3:1];
    assign frame_err  = ~shift_reg[0];

`ifdef MTM_ALU_RX_TIMEOUT_EN
    assign rx_idle = (state_reg == IDLE);
`endif

endmodule

// File: rtl/mtm_alu_rx_ctrl.sv
// mtm_Alu input controller: sequences DATA/CMD frames, checks count/CRC/opcode, drives the result channel.
// Optional inter-frame timeout enabled by defining MTM_ALU_RX_TIMEOUT_EN.
module mtm_alu_rx_ctrl
    import mtm_alu_pkg::*;
#(
    parameter int DATA_FRAMES = 8
`ifdef MTM_ALU_RX_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 1024
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sin,
    mtm_alu_rx_ctrl_if.master core
);
    localparam int              CNT_W    = $clog2(DATA_FRAMES + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_FRAMES);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DATA_FRAMES + 1);

    logic             frame_done, frame_type, frame_err;
    logic [7:0]       payload;
    logic [CNT_W-1:0] frame_cnt_reg, frame_cnt_next;
    logic [63:0]      data_reg, data_next;
    logic             done, timed_out;
    err_t             res_err, out_err_reg;
    logic [2:0]       res_op, out_op_reg;
    logic [31:0]      res_a, res_b, out_a_reg, out_b_reg;
    logic             out_valid_reg, overrun_reg;
`ifdef MTM_ALU_RX_TIMEOUT_EN
    logic             rx_idle;
`endif

    mtm_alu_frame_rx u_frame_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .sin        (sin),
`ifdef MTM_ALU_RX_TIMEOUT_EN
        .rx_idle    (rx_idle),
`endif
        .frame_done (frame_done),
        .frame_type (frame_type),
        .payload    (payload),
        .frame_err  (frame_err)
    );

    always_comb begin
        frame_cnt_next = frame_cnt_reg;
        data_next      = data_reg;
        done           = 1'b0;
        res_err        = '0;
        res_op         = '0;
        res_a          = '0;
        res_b          = '0;
        if (frame_done) begin
            if (frame_err) begin
                done              = 1'b1;
                res_err[ERR_DATA] = 1'b1;
                frame_cnt_next    = '0;
            end else if (!frame_type) begin
                data_next = {data_reg[55:0], payload};
                if (frame_cnt_reg != CNT_SAT) frame_cnt_next = frame_cnt_reg + CNT_W'(1);
            end else begin
                done           = 1'b1;
                frame_cnt_next = '0;
                if (frame_cnt_reg != CNT_FULL) begin
                    res_err[ERR_DATA] = 1'b1;
                end else if (crc4({data_reg, 1'b1, payload[6:4]}) != payload[3:0]) begin
                    res_err[ERR_CRC] = 1'b1;
                end else if (!op_legal(payload[6:4])) begin
                    res_err[ERR_OP] = 1'b1;
                end else begin
                    res_b  = data_reg[63:32];
                    res_a  = data_reg[31:0];
                    res_op = payload[6:4];
                end
            end
        end else if (timed_out) begin
            done              = 1'b1;
            res_err[ERR_DATA] = 1'b1;
            frame_cnt_next    = '0;
        end
    end

`ifdef MTM_ALU_RX_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
    logic [IDLE_W-1:0] idle_cnt_reg;

    assign timed_out = rx_idle && (frame_cnt_reg != '0) &&
                       (idle_cnt_reg == IDLE_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt_reg <= '0;
        end else if (!rx_idle || frame_cnt_reg == '0 || timed_out) begin
            idle_cnt_reg <= '0;
        end else begin
            idle_cnt_reg <= idle_cnt_reg + IDLE_W'(1);
        end
    end
`else
    assign timed_out = 1'b0;
`endif

    // A full, unaccepted output register drops a newly completed result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_reg <= '0;
            data_reg      <= '0;
            out_valid_reg <= 1'b0;
            out_err_reg   <= '0;
            out_op_reg    <= '0;
            out_a_reg     <= '0;
            out_b_reg     <= '0;
            overrun_reg   <= 1'b0;
        end else begin
            frame_cnt_reg <= frame_cnt_next;
            data_reg      <= data_next;
            overrun_reg   <= 1'b0;
            if (done) begin
                if (!out_valid_reg || core.out_ready) begin
                    out_valid_reg <= 1'b1;
                    out_err_reg   <= res_err;
                    out_op_reg    <= res_op;
                    out_a_reg     <= res_a;
                    out_b_reg     <= res_b;
                end else begin
                    overrun_reg <= 1'b1;
                end
            end else if (out_valid_reg && core.out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign core.out_valid = out_valid_reg;
    assign core.out_err   = out_err_reg;
    assign core.out_op    = out_op_reg;
    assign core.out_a     = out_a_reg;
    assign core.out_b     = out_b_reg;
    assign core.overrun   = overrun_reg;

endmodule

// File: tb/tb_mtm_alu_rx_ctrl.sv
// Directed + randomized bench for mtm_alu_rx_ctrl against a frame-level reference model.
module tb_mtm_alu_rx_ctrl;
    import mtm_alu_pkg::*;

    localparam int TIMEOUT_CYC = 1024;
    localparam int N_RANDOM    = 150;

    typedef struct packed {
        logic [2:0]  err;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } res_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic sin   = 1'b1;

    mtm_alu_rx_ctrl_if core_if ();

    mtm_alu_rx_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sin   (sin),
        .core  (core_if)
    );

    always #5 clk = ~clk;

    int         vectors     = 0;
    int         miscompares = 0;
    int         ovr_cnt     = 0;
    bit         rand_ready  = 1'b0;
    logic [7:0] rx_bytes[$];
    res_t       exp_q[$];
    res_t       act_q[$];
    res_t       held;
    bit         held_v = 1'b0;
    res_t       cur;

    assign cur = {core_if.out_err, core_if.out_op, core_if.out_a, core_if.out_b};

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // CRC as the remainder of M(x)*x^4 divided by x^4+x+1.
    function automatic logic [3:0] ref_crc(input logic [67:0] msg);
        logic [71:0] rem;
        rem = {msg, 4'b0000};
        for (int i = 71; i >= 4; i--)
            if (rem[i]) rem[i -: 5] = rem[i -: 5] ^ 5'b10011;
        return rem[3:0];
    endfunction

    function automatic res_t model_cmd(input logic [7:0] pl);
        res_t        r;
        logic [63:0] ba;
        logic [2:0]  op;
        r  = '0;
        ba = '0;
        op = pl[6:4];
        if (rx_bytes.size() != 8) begin
            r.err = 3'b100;
        end else begin
            for (int i = 0; i < 8; i++) ba = {ba[55:0], rx_bytes[i]};
            if (ref_crc({ba, 1'b1, op}) != pl[3:0]) r.err = 3'b010;
            else if (!(op == 3'b000 || op == 3'b001 || op == 3'b100 || op == 3'b101)) r.err = 3'b001;
            else begin
                r.op = op;
                r.b  = ba[63:32];
                r.a  = ba[31:0];
            end
        end
        return r;
    endfunction

    // Accepts, stability while stalled, and overrun pulses, sampled mid-cycle.
    always @(negedge clk) begin
        if (held_v && rst_n) chk("hold_stable", {core_if.out_valid, cur}, {1'b1, held});
        held_v = rst_n && core_if.out_valid && !core_if.out_ready;
        held   = cur;
        if (rst_n && core_if.out_valid && core_if.out_ready) act_q.push_back(cur);
        if (core_if.overrun) ovr_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) core_if.out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send_frame(input bit typ, input logic [7:0] pl, input bit stop, input int gap);
        logic [FRAME_BITS-1:0] f;
        f = {1'b0, typ, pl, stop};
        for (int i = FRAME_BITS - 1; i >= 0; i--) begin
            sin = f[i];
            tick();
        end
        sin = 1'b1;
        for (int i = 0; i < gap; i++) tick();
    endtask

    task automatic data(input logic [7:0] pl, input bit stop);
        send_frame(1'b0, pl, stop, 2);
        if (stop) begin
            rx_bytes.push_back(pl);
        end else begin
            exp_q.push_back(res_t'({3'b100, 67'd0}));
            rx_bytes.delete();
        end
    endtask

    task automatic cmd(input logic [2:0] op, input logic [3:0] crc_xor, input bit drop, input int gap);
        logic [63:0] ba;
        logic [7:0]  pl;
        ba = '0;
        foreach (rx_bytes[i]) ba = {ba[55:0], rx_bytes[i]};
        pl = {1'b0, op, ref_crc({ba, 1'b1, op}) ^ crc_xor};
        if (!drop) exp_q.push_back(model_cmd(pl));
        rx_bytes.delete();
        send_frame(1'b1, pl, 1'b1, gap);
    endtask

    task automatic op_seq(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                          input logic [3:0] crc_xor, input bit drop);
        for (int i = 3; i >= 0; i--) data(b[i*8 +: 8], 1'b1);
        for (int i = 3; i >= 0; i--) data(a[i*8 +: 8], 1'b1);
        cmd(op, crc_xor, drop, 2);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (act_q.size() < exp_q.size() && n < 400) begin
            tick();
            n++;
        end
        repeat (4) tick();
        chk({tag, "_count"}, 72'(act_q.size()), 72'(exp_q.size()));
        while (exp_q.size() > 0 && act_q.size() > 0) chk(tag, act_q.pop_front(), exp_q.pop_front());
        exp_q.delete();
        act_q.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] ops[4];
        int         ovr0;
        ops = '{3'b000, 3'b001, 3'b100, 3'b101};
        core_if.out_ready = 1'b1;
        repeat (3) tick();
        chk("in_reset", {core_if.out_valid, core_if.overrun, cur}, 72'd0);
        rst_n = 1'b1;
        tick();
        chk("reset_state", {core_if.out_valid, core_if.overrun, cur}, 72'd0);

        // Latency and single-cycle valid with out_ready held high.
        for (int i = 0; i < 4; i++) data(8'h00, 1'b1);
        for (int i = 0; i < 4; i++) data(8'hFF, 1'b1);
        cmd(3'b000, 4'h0, 1'b0, 0);
        chk("latency_check_cycle", 72'(core_if.out_valid), 72'd0);
        tick();
        chk("latency_valid", {core_if.out_valid, cur}, {1'b1, 3'b000, 3'b000, 32'hFFFF_FFFF, 32'h0});
        tick();
        chk("valid_one_cycle", 72'(core_if.out_valid), 72'd0);
        drain("and_first");

        for (int k = 1; k < 4; k++) op_seq(32'hFFFF_FFFF, 32'h0, ops[k], 4'h0, 1'b0);
        for (int k = 0; k < 4; k++) op_seq(32'hFFFF_FFFF, 32'hFFFF_FFFF, ops[k], 4'h0, 1'b0);
        drain("legal_ops");

        // Frame count boundaries.
        for (int i = 0; i < 7; i++) data(8'(i + 1), 1'b1);
        cmd(3'b100, 4'h0, 1'b0, 2);
        for (int i = 0; i < 9; i++) data(8'(i + 16), 1'b1);
        cmd(3'b100, 4'h0, 1'b0, 2);
        op_seq(32'h1234_5678, 32'h9ABC_DEF0, 3'b100, 4'h0, 1'b0);
        drain("frame_count");

        // CRC and opcode errors.
        op_seq(32'hDEAD_BEEF, 32'h0BAD_F00D, 3'b101, 4'h1, 1'b0);
        op_seq(32'hDEAD_BEEF, 32'h0BAD_F00D, 3'b111, 4'h0, 1'b0);
        drain("crc_op_err");

        // Overrun while the output register is stalled.
        core_if.out_ready = 1'b0;
        ovr0 = ovr_cnt;
        op_seq(32'h0000_00A5, 32'h0000_005A, 3'b001, 4'h0, 1'b0);
        op_seq(32'h1111_1111, 32'h2222_2222, 3'b100, 4'h0, 1'b1);
        repeat (3) tick();
        chk("overrun_pulses", 72'(ovr_cnt - ovr0), 72'd1);
        chk("held_valid", 72'(core_if.out_valid), 72'd1);
        core_if.out_ready = 1'b1;
        drain("overrun_first");

        // Framing error on the 3rd DATA frame, then recovery.
        data(8'h11, 1'b1);
        data(8'h22, 1'b1);
        data(8'h33, 1'b0);
        op_seq(32'hCAFE_0001, 32'h0000_BEEF, 3'b000, 4'h0, 1'b0);
        drain("framing");

        // Reset mid-way through the 5th DATA frame while a result is held.
        core_if.out_ready = 1'b0;
        op_seq(32'h5555_AAAA, 32'hAAAA_5555, 3'b101, 4'h0, 1'b0);
        for (int i = 0; i < 4; i++) data(8'hC3, 1'b1);
        for (int i = 0; i < 5; i++) begin
            sin = 1'b0;
            tick();
        end
        sin   = 1'b1;
        rst_n = 1'b0;
        #2;
        chk("mid_frame_reset", {core_if.out_valid, core_if.overrun, cur}, 72'd0);
        tick();
        rst_n = 1'b1;
        tick();
        exp_q.delete();
        act_q.delete();
        rx_bytes.delete();
        core_if.out_ready = 1'b1;
        op_seq(32'h0F0F_0F0F, 32'hF0F0_F0F0, 3'b001, 4'h0, 1'b0);
        drain("after_reset");

`ifdef MTM_ALU_RX_TIMEOUT_EN
        for (int i = 0; i < 4; i++) data(8'h77, 1'b1);
        repeat (TIMEOUT_CYC + 10) tick();
        exp_q.push_back(res_t'({3'b100, 67'd0}));
        rx_bytes.delete();
        drain("timeout");
`endif

        // Randomized commands after a dangling partial sequence.
        ovr0 = ovr_cnt;
        for (int i = 0; i < 4; i++) data(8'($urandom_range(0, 255)), 1'b1);
        rand_ready = 1'b1;
        for (int n = 0; n < N_RANDOM; n++) begin
            op_seq($urandom(), $urandom(), 3'($urandom_range(0, 7)),
                   ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'h0, 1'b0);
        end
        rand_ready        = 1'b0;
        core_if.out_ready = 1'b1;
        drain("random");
        chk("random_no_overrun", 72'(ovr_cnt - ovr0), 72'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
